adma_mem: RTL and testbench

ADMA_MEM -- requirements
Module: adma_mem

---
 rtl/sd_mem_pkg.sv | 43 ++++
 rtl/wait_counter.sv | 34 +++
 rtl/adma_mem.sv | 142 ++++++++++++++
 tb/tb_adma_mem.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_mem_pkg.sv
// Shared definitions for the ADMA descriptor memory: FSM states, descriptor
// attribute codes, descriptor layout and the reset-time preload image.
package sd_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] ATTR_TRAN_VALID = 6'b010001;
  localparam logic [5:0] ATTR_LINK_VALID = 6'b110001;

  // Byte offsets of each descriptor and of the words within a descriptor
  localparam int unsigned DESC0_OFF = 32'h00;
  localparam int unsigned DESC1_OFF = 32'h10;
  localparam int unsigned DESC2_OFF = 32'h20;
  localparam int unsigned DESC_W0_OFF = 32'h0;
  localparam int unsigned DESC_W1_OFF = 32'h4;
  localparam int unsigned DESC_W2_OFF = 32'h8;
  localparam int unsigned DESC_W3_OFF = 32'hC;

  function automatic logic [31:0] desc_word0(input logic [15:0] len, input logic [5:0] attr);
    return {len, 10'b0, attr};
  endfunction

  // Upper address halves (word2) and word3 of every descriptor are zero.
  function automatic logic [31:0] preload_word(input int unsigned byte_off);
    logic [31:0] w;
    w = '0;
    case (byte_off)
      DESC0_OFF + DESC_W0_OFF: w = desc_word0(16'd5, ATTR_TRAN_VALID);
      DESC0_OFF + DESC_W1_OFF: w = 32'h0000_0040;
      DESC1_OFF + DESC_W0_OFF: w = desc_word0(16'd5, ATTR_TRAN_VALID);
      DESC1_OFF + DESC_W1_OFF: w = 32'h0000_0080;
      DESC2_OFF + DESC_W0_OFF: w = desc_word0(16'd0, ATTR_LINK_VALID);
      DESC2_OFF + DESC_W1_OFF: w = 32'h0000_0000;
      default:                 w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loaded with LATENCY on accept, decremented while
// the FSM waits; done flags the final wait cycle.
module wait_counter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(LATENCY);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/adma_mem.sv
// Wait-stated word memory holding the ADMA descriptor table, with byte-enabled
// writes, alignment/range/conflict error reporting and a one-cycle ack pulse.
module adma_mem
  import sd_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LATENCY    = 2,
  parameter bit          PRELOAD    = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RESET_L,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    write,
  input  logic                    read,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    ack,
  output logic                    error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);

  state_e state_q, state_d;
  logic   rst_done_q;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [BYTES-1:0]      be_q;
  logic                  rd_q, wr_q;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  ack_q, err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept, in_wait, in_done, cnt_done, req_err;
  logic                  do_write, do_read;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      idx;

  // ready is held low for one cycle after reset release, even though the
  // state register already sits in IDLE during reset.
  assign ready   = (state_q == ST_IDLE) && rst_done_q;
  assign accept  = ready && (read || write);
  assign in_wait = (state_q == ST_WAIT);
  assign in_done = (state_q == ST_DONE);

  assign word_idx = addr_q >> OFF_W;
  assign idx      = word_idx[IDX_W-1:0];
  assign req_err  = (|(addr_q & ALIGN_MASK)) || (word_idx >= DEPTH_A) || (rd_q && wr_q);
  assign do_write = in_done && !req_err && wr_q;
  assign do_read  = in_done && !req_err && rd_q;

  wait_counter #(
    .LATENCY(LATENCY)
  ) u_wait_counter (
    .clk_i (CLK),
    .rst_ni(RESET_L),
    .load_i(accept),
    .dec_i (in_wait),
    .done_o(cnt_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (LATENCY == 0) ? ST_DONE : ST_WAIT;
      ST_WAIT: if (cnt_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= address;
      data_q <= data_in;
      be_q   <= byte_en;
      rd_q   <= read;
      wr_q   <= write;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      data_out_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= in_done;
      err_q <= in_done && req_err;
      if (do_read) begin
        data_out_q <= mem_q[idx];
      end
    end
  end

  // Without preload the array is left untouched by reset so contents survive.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      if (PRELOAD) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[i] <= DATA_WIDTH'(preload_word(i * BYTES));
        end
      end
    end else if (do_write) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (be_q[b]) begin
          mem_q[idx][8*b +: 8] <= data_q[8*b +: 8];
        end
      end
    end
  end

  assign data_out = data_out_q;
  assign ack      = ack_q;
  assign error    = err_q;

endmodule

// File: tb/tb_adma_mem.sv
// Scoreboard bench for adma_mem: three instances (preload/LATENCY=2,
// no-preload/LATENCY=2, preload/LATENCY=0) driven sequentially.
module tb_adma_mem;

  logic        CLK;
  logic        rst_n [3];
  logic [63:0] addr  [3];
  logic [31:0] din   [3];
  logic [3:0]  be    [3];
  logic        rd    [3];
  logic        wr    [3];
  logic        rdy   [3];
  logic [31:0] dout  [3];
  logic        ack   [3];
  logic        err   [3];

  typedef struct {
    int          k;
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] last [3];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc  = 0;
  int          acc1, acc2, acc_dummy;

  adma_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(2), .PRELOAD(1'b1)) u_dut (
    .CLK(CLK), .RESET_L(rst_n[0]), .address(addr[0]), .data_in(din[0]), .byte_en(be[0]),
    .write(wr[0]), .read(rd[0]), .ready(rdy[0]), .data_out(dout[0]), .ack(ack[0]), .error(err[0]));

  adma_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(2), .PRELOAD(1'b0)) u_dut_np (
    .CLK(CLK), .RESET_L(rst_n[1]), .address(addr[1]), .data_in(din[1]), .byte_en(be[1]),
    .write(wr[1]), .read(rd[1]), .ready(rdy[1]), .data_out(dout[1]), .ack(ack[1]), .error(err[1]));

  adma_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(0), .PRELOAD(1'b1)) u_dut_l0 (
    .CLK(CLK), .RESET_L(rst_n[2]), .address(addr[2]), .data_in(din[2]), .byte_en(be[2]),
    .write(wr[2]), .read(rd[2]), .ready(rdy[2]), .data_out(dout[2]), .ack(ack[2]), .error(err[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  // Drive one request once the instance is ready; the expected completion is
  // queued at the accept edge.
  task automatic issue(input int k, input logic r, input logic w, input logic [63:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] xd,
                       input logic xe, input string tag, output int acc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge CLK);
    while (!rdy[k] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, " ready"}, 64'(rdy[k]), 64'd1);
    addr[k] = a; din[k] = d; be[k] = b; rd[k] = r; wr[k] = w;
    @(posedge CLK);
    #1;
    acc = cyc;
    if (r && !w && !xe) last[k] = xd;
    e.k = k; e.data = last[k]; e.err = xe; e.cyc = cyc + lat_of(k) + 1; e.tag = tag;
    sb.push_back(e);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ack[k]) begin
        if (sb.size() == 0 || sb[0].k != k) begin
          check($sformatf("spurious ack inst%0d", k), 64'(ack[k]), 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, " data"}, 64'(dout[k]), 64'(e.data));
          check({e.tag, " error"}, 64'(err[k]), 64'(e.err));
          check({e.tag, " ack cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end else if (err[k]) begin
        check($sformatf("error without ack inst%0d", k), 64'(err[k]), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; addr[k] = '0; din[k] = '0; be[k] = '0;
      rd[k] = 1'b0; wr[k] = 1'b0; last[k] = '0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ready inst%0d", k), 64'(rdy[k]), 64'd0);
      check($sformatf("reset ack inst%0d", k), 64'(ack[k]), 64'd0);
      check($sformatf("reset error inst%0d", k), 64'(err[k]), 64'd0);
      check($sformatf("reset data_out inst%0d", k), 64'(dout[k]), 64'd0);
      rst_n[k] = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 3; k++)
      check($sformatf("ready after release inst%0d", k), 64'(rdy[k]), 64'd1);

    // Preload image and latency
    issue(0, 1, 0, 64'h00, '0, '0, 32'h0005_0011, 0, "rd desc0 w0", acc_dummy);
    issue(0, 1, 0, 64'h04, '0, '0, 32'h0000_0040, 0, "rd desc0 w1", acc_dummy);
    issue(0, 1, 0, 64'h10, '0, '0, 32'h0005_0011, 0, "rd desc1 w0", acc_dummy);
    issue(0, 1, 0, 64'h14, '0, '0, 32'h0000_0080, 0, "rd desc1 w1", acc_dummy);
    issue(0, 1, 0, 64'h20, '0, '0, 32'h0000_0031, 0, "rd desc2 w0", acc_dummy);
    issue(0, 1, 0, 64'h24, '0, '0, 32'h0000_0000, 0, "rd desc2 w1", acc_dummy);
    issue(0, 1, 0, 64'h28, '0, '0, 32'h0000_0000, 0, "rd desc2 w2", acc_dummy);
    // Byte-enabled writes
    issue(0, 0, 1, 64'h40, 32'hDEAD_BEEF, 4'b0011, '0, 0, "wr 40 be3", acc_dummy);
    issue(0, 1, 0, 64'h40, '0, '0, 32'h0000_BEEF, 0, "rd 40 after be3", acc_dummy);
    issue(0, 0, 1, 64'h40, 32'hFFFF_FFFF, 4'b0000, '0, 0, "wr 40 be0", acc_dummy);
    issue(0, 1, 0, 64'h40, '0, '0, 32'h0000_BEEF, 0, "rd 40 after be0", acc_dummy);
    issue(0, 0, 1, 64'h40, 32'h1234_5678, 4'b1100, '0, 0, "wr 40 beC", acc_dummy);
    issue(0, 1, 0, 64'h40, '0, '0, 32'h1234_BEEF, 0, "rd 40 after beC", acc_dummy);
    // Error cases leave memory and data_out alone
    issue(0, 1, 0, 64'h42, '0, '0, '0, 1, "rd misaligned 42", acc_dummy);
    issue(0, 1, 0, 64'h100, '0, '0, '0, 1, "rd out of range 100", acc_dummy);
    issue(0, 1, 0, 64'h1_0000_0040, '0, '0, '0, 1, "rd high addr bits", acc_dummy);
    issue(0, 0, 1, 64'h42, 32'hAAAA_AAAA, 4'hF, '0, 1, "wr misaligned 42", acc_dummy);
    issue(0, 1, 0, 64'h40, '0, '0, 32'h1234_BEEF, 0, "rd 40 after bad wr", acc_dummy);
    issue(0, 0, 1, 64'hFC, 32'hA5A5_A5A5, 4'hF, '0, 0, "wr last word", acc_dummy);
    issue(0, 1, 0, 64'hFC, '0, '0, 32'hA5A5_A5A5, 0, "rd last word", acc_dummy);
    issue(0, 1, 1, 64'h40, 32'h0, 4'hF, '0, 1, "rd+wr conflict", acc_dummy);
    issue(0, 1, 0, 64'h40, '0, '0, 32'h1234_BEEF, 0, "rd 40 after conflict", acc_dummy);
    drain();

    // No-preload instance: pending write abandoned by reset
    issue(1, 0, 1, 64'h40, 32'h1234_5678, 4'hF, '0, 0, "np wr 40", acc_dummy);
    issue(1, 1, 0, 64'h40, '0, '0, 32'h1234_5678, 0, "np rd 40", acc_dummy);
    drain();
    @(negedge CLK);
    addr[1] = 64'h40; din[1] = 32'hCAFE_F00D; be[1] = 4'hF; wr[1] = 1'b1;
    @(posedge CLK);
    #1;
    wr[1] = 1'b0;
    @(negedge CLK);
    check("np ready low in wait", 64'(rdy[1]), 64'd0);
    rst_n[1] = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("np ready in reset", 64'(rdy[1]), 64'd0);
    check("np data_out in reset", 64'(dout[1]), 64'd0);
    rst_n[1] = 1'b1;
    last[1] = '0;
    @(posedge CLK);
    @(negedge CLK);
    check("np ready after release", 64'(rdy[1]), 64'd1);
    repeat (4) @(negedge CLK);
    issue(1, 1, 0, 64'h40, '0, '0, 32'h1234_5678, 0, "np rd 40 retained", acc_dummy);
    drain();

    // LATENCY=0 back-to-back reads
    issue(2, 1, 0, 64'h00, '0, '0, 32'h0005_0011, 0, "l0 rd 0", acc1);
    @(negedge CLK);
    check("l0 ready in done", 64'(rdy[2]), 64'd0);
    issue(2, 1, 0, 64'h04, '0, '0, 32'h0000_0040, 0, "l0 rd 4", acc2);
    check("l0 accept spacing", 64'(acc2 - acc1), 64'd2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
